// File: rtl/oseq_pkg.sv
// Shared definitions for the oseq_gen symbol sequencer.
//   state_t       : controller states
//   MODE_GEN/REPLAY : values of the mode input
//   DEFAULT_SEED/TAPS : default LFSR reset seed and feedback mask
package oseq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    FETCH,
    PRESENT,
    DONE
  } state_t;

  localparam logic MODE_GEN    = 1'b0;
  localparam logic MODE_REPLAY = 1'b1;

  localparam logic [15:0] DEFAULT_SEED = 16'hBEEF;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

endpackage

// File: rtl/oseq_lfsr.sv
// Fibonacci LFSR with load and step enables.
//   clk, rst : clock, asynchronous active-high reset (state <= SEED)
//   load     : load load_val (an all-zero value is replaced by SEED)
//   load_val : value to load
//   step     : advance one position (load wins over step)
//   sym      : low SYM_W bits of the current state
module oseq_lfsr
  import oseq_pkg::*;
#(
  parameter int unsigned         LFSR_W = 16,
  parameter logic [LFSR_W-1:0]   TAPS   = DEFAULT_TAPS,
  parameter logic [LFSR_W-1:0]   SEED   = DEFAULT_SEED,
  parameter int unsigned         SYM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [SYM_W-1:0]  sym
);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] state_next;
  logic              fb;

  always_comb begin
    fb         = ^(state & TAPS);
    state_next = {state[LFSR_W-2:0], fb};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      // An all-zero state would lock the register, so substitute the seed.
      state <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      state <= state_next;
    end
  end

  assign sym = state[SYM_W-1:0];

endmodule

// File: rtl/oseq_gen.sv
// Sequence generator / replayer.
// GENERATE writes seq_len LFSR symbols into internal memory; REPLAY streams
// the stored sequence over a valid/ready handshake (one symbol per 2 cycles).
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin operation (IDLE only)
//   mode       : 0 = GENERATE, 1 = REPLAY
//   seq_len    : sequence length 1..DEPTH, sampled with start
//   seed_load  : load seed into LFSR (IDLE only, beats start)
//   seed       : seed value
//   sym_data   : replayed symbol
//   sym_valid  : sym_data valid
//   sym_ready  : consumer accepts symbol
//   sym_idx    : index of symbol being written or presented
//   busy       : not IDLE
//   finish     : one-cycle completion pulse
//   err        : one-cycle pulse on a rejected start
module oseq_gen
  import oseq_pkg::*;
#(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = DEFAULT_TAPS,
  parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
  parameter int unsigned       SYM_W  = 4,
  parameter int unsigned       DEPTH  = 32,
  parameter int unsigned       ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W:0]   seq_len,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [SYM_W-1:0]  sym_data,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [ADDR_W-1:0] sym_idx,
  output logic              busy,
  output logic              finish,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state, state_next;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   stored_len;
  logic [ADDR_W-1:0] wr;
  logic [ADDR_W-1:0] rd;
  logic [SYM_W-1:0]  rdata;
  logic              err_q;
  logic [SYM_W-1:0]  lfsr_sym;
  logic [SYM_W-1:0]  mem [DEPTH];

  logic lfsr_load, lfsr_step, mem_we, rd_en;
  logic gen_go, gen_last, rep_go, rd_inc, err_next;

  oseq_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED),
    .SYM_W  (SYM_W)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed),
    .step     (lfsr_step),
    .sym      (lfsr_sym)
  );

  always_comb begin
    state_next = state;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    mem_we     = 1'b0;
    rd_en      = 1'b0;
    gen_go     = 1'b0;
    gen_last   = 1'b0;
    rep_go     = 1'b0;
    rd_inc     = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
        end else if (start) begin
          if (mode == MODE_GEN) begin
            if (seq_len == '0 || seq_len > DEPTH_L) begin
              err_next = 1'b1;
            end else begin
              gen_go     = 1'b1;
              state_next = GEN;
            end
          end else if (mode == MODE_REPLAY) begin
            if (stored_len == '0) begin
              err_next = 1'b1;
            end else begin
              rep_go     = 1'b1;
              state_next = FETCH;
            end
          end
        end
      end
      GEN: begin
        mem_we    = 1'b1;
        lfsr_step = 1'b1;
        if ({1'b0, wr} == len - 1'b1) begin
          gen_last   = 1'b1;
          state_next = DONE;
        end
      end
      FETCH: begin
        rd_en      = 1'b1;
        state_next = PRESENT;
      end
      PRESENT: begin
        if (sym_ready) begin
          if ({1'b0, rd} == stored_len - 1'b1) begin
            state_next = DONE;
          end else begin
            rd_inc     = 1'b1;
            state_next = FETCH;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      stored_len <= '0;
      wr         <= '0;
      rd         <= '0;
      rdata      <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_next;
      err_q <= err_next;
      if (gen_go) begin
        len <= seq_len;
        wr  <= '0;
      end
      // wr rolls over after a full-depth run, but no write follows it.
      if (mem_we)   wr         <= wr + 1'b1;
      if (gen_last) stored_len <= len;
      if (rep_go)   rd         <= '0;
      if (rd_inc)   rd         <= rd + 1'b1;
      if (rd_en)    rdata      <= mem[rd];
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr] <= lfsr_sym;
  end

  always_comb begin
    busy      = (state != IDLE);
    finish    = (state == DONE);
    sym_valid = (state == PRESENT);
    err       = err_q;
    sym_data  = rdata;
    case (state)
      GEN:           sym_idx = wr;
      FETCH, PRESENT: sym_idx = rd;
      default:       sym_idx = '0;
    endcase
  end

endmodule

// File: tb/tb_oseq_gen.sv
// Directed testbench for oseq_gen (default parameters).
module tb_oseq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [5:0]  seq_len = '0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic [3:0]  sym_data;
  logic        sym_valid;
  logic        sym_ready = 1'b0;
  logic [4:0]  sym_idx;
  logic        busy;
  logic        finish;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [3:0] cap_d[$];
  logic [4:0] cap_ix[$];

  oseq_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .seq_len   (seq_len),
    .seed_load (seed_load),
    .seed      (seed),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_idx   (sym_idx),
    .busy      (busy),
    .finish    (finish),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    start = 1'b0; seed_load = 1'b0; sym_ready = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_load = 1'b1; seed = s;
    tick;
    seed_load = 1'b0;
  endtask

  task automatic gen_run(input int len, output int busy_cyc, output int fin_cnt,
                         output int err_cnt, output bit to);
    mode = 1'b0; seq_len = len[5:0]; start = 1'b1;
    tick;
    start = 1'b0;
    busy_cyc = 0; fin_cnt = 0; err_cnt = 0; to = 1'b1;
    for (int k = 1; k <= len + 20; k++) begin
      if (busy) busy_cyc++;
      if (finish) fin_cnt++;
      if (err) err_cnt++;
      if (!busy) begin to = 1'b0; break; end
      tick;
    end
  endtask

  task automatic replay_run(output int fin_cnt, output int err_cnt, output bit to);
    cap_d.delete(); cap_ix.delete();
    mode = 1'b1; sym_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    fin_cnt = 0; err_cnt = 0; to = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      if (sym_valid) begin cap_d.push_back(sym_data); cap_ix.push_back(sym_idx); end
      if (finish) fin_cnt++;
      if (err) err_cnt++;
      if (!busy) begin to = 1'b0; break; end
      tick;
    end
    sym_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++;
    if ({sym_data, sym_valid, sym_idx, busy, finish, err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {sym_data, sym_valid, sym_idx, busy, finish, err});
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_gen_basic;
    int busy_cyc = 0, fin_cnt = 0, fin_at = 0;
    mode = 1'b0; seq_len = 6'd3; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (busy) busy_cyc++;
      if (finish) begin fin_cnt++; fin_at = k; end
      if (k <= 3) begin
        checks++;
        if (sym_idx !== 5'(k - 1)) begin
          errors++;
          $display("FAIL gen3_idx[%0d]: got %0d required %0d", k, sym_idx, k - 1);
        end
      end
      tick;
    end
    checks++;
    if (busy_cyc !== 4) begin errors++; $display("FAIL gen3_busy: got %0d required 4", busy_cyc); end
    checks++;
    if (fin_cnt !== 1) begin errors++; $display("FAIL gen3_finish_count: got %0d required 1", fin_cnt); end
    checks++;
    if (fin_at !== 4) begin errors++; $display("FAIL gen3_finish_at: got %0d required 4", fin_at); end
  endtask

  task automatic test_replay_stall;
    int lat = 0, fin_cnt = 0;
    bit found = 1'b0;
    mode = 1'b1; sym_ready = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (sym_valid) begin found = 1'b1; lat = k; break; end
      tick;
    end
    checks++;
    if (!found || lat != 2) begin
      errors++;
      $display("FAIL replay_first_valid: got cycle %0d (found=%0d) required 2", lat, found);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({sym_valid, sym_data, sym_idx} !== {1'b1, 4'hF, 5'd0}) begin
        errors++;
        $display("FAIL replay_hold[%0d]: got v=%0d d=%h i=%0d required v=1 d=f i=0",
                 c, sym_valid, sym_data, sym_idx);
      end
      if (c == 2) sym_ready = 1'b1;
      tick;
    end
    cap_d.delete(); cap_ix.delete();
    for (int k = 0; k < 20; k++) begin
      if (sym_valid) begin cap_d.push_back(sym_data); cap_ix.push_back(sym_idx); end
      if (finish) fin_cnt++;
      if (!busy) break;
      tick;
    end
    sym_ready = 1'b0;
    checks++;
    if (cap_d.size() != 2) begin
      errors++;
      $display("FAIL replay_rest_count: got %0d required 2", cap_d.size());
    end else begin
      checks++;
      if ({cap_d[0], cap_ix[0], cap_d[1], cap_ix[1]} !== {4'hE, 5'd1, 4'hD, 5'd2}) begin
        errors++;
        $display("FAIL replay_rest_data: got %h/%0d %h/%0d required e/1 d/2",
                 cap_d[0], cap_ix[0], cap_d[1], cap_ix[1]);
      end
    end
    checks++;
    if (fin_cnt !== 1) begin errors++; $display("FAIL replay_finish: got %0d required 1", fin_cnt); end
  endtask

  task automatic test_replay_empty;
    bit valid_seen = 1'b0, busy_seen = 1'b0;
    apply_reset;
    mode = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (sym_valid) valid_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (k == 1) begin
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL empty_err_pulse: got %0d required 1", err); end
      end
      if (k == 2) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL empty_err_width: got %0d required 0", err); end
      end
      tick;
    end
    checks++;
    if ({valid_seen, busy_seen} !== 2'b00) begin
      errors++;
      $display("FAIL empty_quiet: got valid=%0d busy=%0d required 0 0", valid_seen, busy_seen);
    end
  endtask

  task automatic test_seed;
    int b, f, e, rf, re;
    bit to, rto;
    logic [3:0] exp_sym [3] = '{4'hF, 4'h1, 4'h2};
    // seed 0 -> default seed; seed 1 -> symbol 1, then 2 after one step
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin load_seed(16'h0001); load_seed(16'h0000); end
      if (i == 1) load_seed(16'h0001);
      gen_run(1, b, f, e, to);
      replay_run(rf, re, rto);
      checks++;
      if (to || rto || cap_d.size() != 1) begin
        errors++;
        $display("FAIL seed_run[%0d]: timeout=%0d/%0d count=%0d required 1", i, to, rto, cap_d.size());
      end else begin
        checks++;
        if (cap_d[0] !== exp_sym[i]) begin
          errors++;
          $display("FAIL seed_sym[%0d]: got %h required %h", i, cap_d[0], exp_sym[i]);
        end
      end
    end
    seed_load = 1'b1; seed = 16'h0001; start = 1'b1; mode = 1'b0; seq_len = 6'd1;
    tick;
    seed_load = 1'b0; start = 1'b0;
    checks++;
    if ({busy, err} !== 2'b00) begin
      errors++;
      $display("FAIL seed_start_priority: got busy=%0d err=%0d required 0 0", busy, err);
    end
    gen_run(1, b, f, e, to);
    replay_run(rf, re, rto);
    checks++;
    if (cap_d.size() != 1 || cap_d[0] !== 4'h1) begin
      errors++;
      $display("FAIL seed_priority_sym: got count=%0d required one symbol 1", cap_d.size());
    end
  endtask

  task automatic test_full_depth;
    int b, f, e, rf, re;
    bit to, rto;
    logic [15:0] m = 16'h0001;
    logic [3:0] exp_d;
    load_seed(16'h0001);
    gen_run(32, b, f, e, to);
    checks++;
    if (to || b != 33 || f != 1) begin
      errors++;
      $display("FAIL full_gen: got busy=%0d finish=%0d timeout=%0d required 33 1 0", b, f, to);
    end
    replay_run(rf, re, rto);
    checks++;
    if (rto || cap_d.size() != 32 || rf != 1) begin
      errors++;
      $display("FAIL full_replay_count: got %0d finish=%0d required 32 1", cap_d.size(), rf);
    end else begin
      for (int i = 0; i < 32; i++) begin
        exp_d = m[3:0];
        m = {m[14:0], ^(m & 16'hB400)};
        checks++;
        if (cap_d[i] !== exp_d || cap_ix[i] !== 5'(i)) begin
          errors++;
          $display("FAIL full_sym[%0d]: got %h/%0d required %h/%0d", i, cap_d[i], cap_ix[i], exp_d, i);
        end
      end
    end
    for (int j = 0; j < 2; j++) begin
      gen_run((j == 0) ? 33 : 0, b, f, e, to);
      checks++;
      if (e != 1 || b != 0) begin
        errors++;
        $display("FAIL bad_len[%0d]: got err=%0d busy=%0d required 1 0", j, e, b);
      end
    end
    replay_run(rf, re, rto);
    checks++;
    if (cap_d.size() != 32 || cap_d[0] !== 4'h1) begin
      errors++;
      $display("FAIL full_after_bad: got count=%0d required 32 with first symbol 1", cap_d.size());
    end
  endtask

  task automatic test_reset_mid;
    int b, f, e, rf, re;
    bit to, rto;
    mode = 1'b0; seq_len = 6'd5; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({sym_data, sym_valid, sym_idx, busy, finish, err} !== 13'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h required 0",
               {sym_data, sym_valid, sym_idx, busy, finish, err});
    end
    tick;
    rst = 1'b0;
    tick;
    replay_run(rf, re, rto);
    checks++;
    if (re != 1 || cap_d.size() != 0) begin
      errors++;
      $display("FAIL midrst_replay: got err=%0d count=%0d required 1 0", re, cap_d.size());
    end
    gen_run(1, b, f, e, to);
    replay_run(rf, re, rto);
    checks++;
    if (cap_d.size() != 1 || cap_d[0] !== 4'hF) begin
      errors++;
      $display("FAIL midrst_seed: got count=%0d required one symbol f", cap_d.size());
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_gen_basic;
    test_replay_stall;
    test_replay_empty;
    test_seed;
    test_full_depth;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
